// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Imported by the register file top and its forwarding mux.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 3;
  localparam int DEF_NWR   = 2;

endpackage

// File: rtl/regfile_fwd.sv
// Per-read-port forwarding mux: picks same-cycle write data
// (highest write port wins) over the stored entry value.
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int AW       = 5,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [AW-1:0]       i_addr,
  input  logic [XLEN-1:0]     i_mem,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0]     o_data
);

  // later ports override earlier ones; entry 0 forced to zero last
  always_comb begin
    o_data = i_mem;
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] &&
            i_wr_addr[j*AW +: AW] == i_addr)
          o_data = i_wr_data[j*XLEN +: XLEN];
      end
    end
    if (ZERO_REG != 0 && i_addr == '0)
      o_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, optional bypass
// and a sweep-based clear that also runs after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                clear_req,
  output logic                busy
);

  logic [XLEN-1:0]     r_mem [NREGS];
  state_t              r_state;
  logic [AW-1:0]       r_idx;
  logic                r_busy;
  logic [NRD*XLEN-1:0] r_rd_data;

  logic                w_idle;
  logic [NWR-1:0]      w_wr_en;
  logic [NRD*XLEN-1:0] w_fwd;

  assign w_idle  = (r_state == IDLE);
  assign w_wr_en = wr_en & {NWR{w_idle}};
  assign rd_data = r_rd_data;
  assign busy    = r_busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_mem;
    assign w_addr = rd_addr[i*AW +: AW];
    assign w_mem  = r_mem[w_addr];

    regfile_fwd #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_fwd (
      .i_addr    (w_addr),
      .i_mem     (w_mem),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_data    (w_fwd[i*XLEN +: XLEN])
    );
  end

  // array update: sweep zeroing or port writes, last port wins
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (r_state == CLEAR) begin
        r_mem[r_idx] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] &&
              (ZERO_REG == 0 ||
               wr_addr[j*AW +: AW] != '0))
            r_mem[wr_addr[j*AW +: AW]] <=
              wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // control FSM with registered reads and busy flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= CLEAR;
      r_idx     <= '0;
      r_busy    <= 1'b1;
      r_rd_data <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          for (int i = 0; i < NRD; i++) begin
            if (rd_en[i])
              r_rd_data[i*XLEN +: XLEN] <=
                w_fwd[i*XLEN +: XLEN];
          end
          if (clear_req) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          r_rd_data <= '0;
          r_idx     <= r_idx + 1'b1;
          if (r_idx == AW'(NREGS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// Default parameters: XLEN=32, NREGS=32, NRD=3, NWR=2.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;
  localparam int NWR  = 2;

  logic                clk;
  logic                rstn;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                clear_req;
  logic                busy;

  int total;
  int bad;

  regfile_mp dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_en     = '0;
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0;
    quiet();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=1", busy);
    end
    total++;
    if (rd_data !== '0) begin
      bad++;
      $display("FAIL reset_rd got=%h exp=0", rd_data);
    end
    rstn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL reset_sweep_len got=%0d exp=32", n);
    end
    for (int a = 0; a < 32; a++) begin
      rd_en = 3'b001;
      rd_addr = '0;
      rd_addr[0 +: AW] = AW'(a);
      tick();
      total++;
      if (rd_data[0 +: XLEN] !== 32'h0) begin
        bad++;
        $display("FAIL reset_entry%0d got=%h exp=0",
                 a, rd_data[0 +: XLEN]);
      end
    end
    quiet();
  endtask

  task automatic test_write_read();
    quiet();
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 5'd5;
    wr_data[0 +: XLEN] = 32'hDEADBEEF;
    tick();
    quiet();
    rd_en = 3'b100;
    rd_addr[2*AW +: AW] = 5'd5;
    tick();
    total++;
    if (rd_data[2*XLEN +: XLEN] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_rd_p2 got=%h exp=deadbeef",
               rd_data[2*XLEN +: XLEN]);
    end
    rd_en = 3'b000;
    rd_addr[2*AW +: AW] = 5'd9;
    tick();
    total++;
    if (rd_data[2*XLEN +: XLEN] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_hold got=%h exp=deadbeef",
               rd_data[2*XLEN +: XLEN]);
    end
    quiet();
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 5'd12;
    wr_data[0 +: XLEN] = 32'h0BAD_F00D;
    rd_en = 3'b010;
    rd_addr[1*AW +: AW] = 5'd12;
    tick();
    total++;
    if (rd_data[1*XLEN +: XLEN] !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL bypass_single got=%h exp=0badf00d",
               rd_data[1*XLEN +: XLEN]);
    end
    quiet();
  endtask

  task automatic test_same_addr();
    quiet();
    wr_en = 2'b11;
    wr_addr[0 +: AW] = 5'd7;
    wr_addr[AW +: AW] = 5'd7;
    wr_data[0 +: XLEN] = 32'h11;
    wr_data[XLEN +: XLEN] = 32'h22;
    rd_en = 3'b001;
    rd_addr[0 +: AW] = 5'd7;
    tick();
    total++;
    if (rd_data[0 +: XLEN] !== 32'h22) begin
      bad++;
      $display("FAIL prio_bypass got=%h exp=22",
               rd_data[0 +: XLEN]);
    end
    quiet();
    tick();
    rd_en = 3'b010;
    rd_addr[AW +: AW] = 5'd7;
    tick();
    total++;
    if (rd_data[XLEN +: XLEN] !== 32'h22) begin
      bad++;
      $display("FAIL prio_stored got=%h exp=22",
               rd_data[XLEN +: XLEN]);
    end
    quiet();
  endtask

  task automatic test_zero_reg();
    quiet();
    wr_en = 2'b10;
    wr_addr[AW +: AW] = 5'd0;
    wr_data[XLEN +: XLEN] = 32'hFFFFFFFF;
    rd_en = 3'b010;
    rd_addr[AW +: AW] = 5'd0;
    tick();
    total++;
    if (rd_data[XLEN +: XLEN] !== 32'h0) begin
      bad++;
      $display("FAIL zero_bypass got=%h exp=0",
               rd_data[XLEN +: XLEN]);
    end
    quiet();
    rd_en = 3'b100;
    rd_addr[2*AW +: AW] = 5'd0;
    tick();
    total++;
    if (rd_data[2*XLEN +: XLEN] !== 32'h0) begin
      bad++;
      $display("FAIL zero_stored got=%h exp=0",
               rd_data[2*XLEN +: XLEN]);
    end
    quiet();
  endtask

  task automatic test_clear();
    int n;
    quiet();
    for (int a = 1; a < 32; a += 2) begin
      wr_en = (a + 1 < 32) ? 2'b11 : 2'b01;
      wr_addr[0 +: AW] = AW'(a);
      wr_addr[AW +: AW] = AW'(a + 1);
      wr_data[0 +: XLEN] = 32'h1000_0000 | a;
      wr_data[XLEN +: XLEN] = 32'h1000_0000 | (a + 1);
      tick();
    end
    quiet();
    rd_en = 3'b111;
    rd_addr[0 +: AW] = 5'd1;
    rd_addr[AW +: AW] = 5'd20;
    rd_addr[2*AW +: AW] = 5'd31;
    tick();
    total++;
    if (rd_data !== {32'h1000_001F, 32'h1000_0014,
                     32'h1000_0001}) begin
      bad++;
      $display("FAIL fill_rd got=%h exp=1000001f_10000014_10000001",
               rd_data);
    end
    quiet();
    clear_req = 1'b1;
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 5'd9;
    wr_data[0 +: XLEN] = 32'hAB;
    tick();
    quiet();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_start got=%b exp=1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      wr_en = 2'b01;
      wr_addr[0 +: AW] = 5'd3;
      wr_data[0 +: XLEN] = 32'h55;
      clear_req = 1'b1;
      rd_en = 3'b111;
      rd_addr[0 +: AW] = 5'd3;
      rd_addr[AW +: AW] = 5'd20;
      rd_addr[2*AW +: AW] = 5'd31;
      tick();
      n++;
      if (n == 1) begin
        total++;
        if (rd_data !== '0) begin
          bad++;
          $display("FAIL clear_rd_zero got=%h exp=0", rd_data);
        end
      end
    end
    quiet();
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL clear_len got=%0d exp=32", n);
    end
    for (int a = 0; a < 32; a++) begin
      rd_en = 3'b001;
      rd_addr[0 +: AW] = AW'(a);
      tick();
      total++;
      if (rd_data[0 +: XLEN] !== 32'h0) begin
        bad++;
        $display("FAIL clear_entry%0d got=%h exp=0",
                 a, rd_data[0 +: XLEN]);
      end
    end
    quiet();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    quiet();
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 5'd30;
    wr_data[0 +: XLEN] = 32'h77;
    tick();
    quiet();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rstn = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || rd_data !== '0) begin
      bad++;
      $display("FAIL mid_reset busy=%b rd=%h exp=1,0",
               busy, rd_data);
    end
    rstn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL mid_restart_len got=%0d exp=32", n);
    end
    rd_en = 3'b001;
    rd_addr[0 +: AW] = 5'd30;
    tick();
    total++;
    if (rd_data[0 +: XLEN] !== 32'h0) begin
      bad++;
      $display("FAIL mid_entry30 got=%h exp=0",
               rd_data[0 +: XLEN]);
    end
    quiet();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    quiet();
    test_reset();
    test_write_read();
    test_same_addr();
    test_zero_reg();
    test_clear();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, number of entries; power of two, at least 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 3, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter ZERO_REG, default 1; when 1, entry 0 reads 0 and ignores writes.
REQ-006 Parameter BYPASS, default 1; when 1, same-cycle write data forwards to reads.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 rd_en  in  NRD  per-port read enable.
REQ-010 rd_addr  in  NRD x AW  per-port read address.
REQ-011 rd_data  out  NRD x XLEN  per-port registered read data.
REQ-012 wr_en  in  NWR  per-port write enable.
REQ-013 wr_addr  in  NWR x AW  per-port write address.
REQ-014 wr_data  in  NWR x XLEN  per-port write data.
REQ-015 clear_req  in  1  one-cycle request to zero the whole array.
REQ-016 busy  out  1  high while a clear sweep is in progress.

Function
REQ-017 FSM with two states: IDLE and CLEAR; clear index idx is AW bits wide.
REQ-018 IDLE: clear_req=1 -> CLEAR with idx=0 and busy=1 at the next edge.
REQ-019 CLEAR: each cycle writes 0 to entry idx and increments idx.
REQ-020 CLEAR: when idx=NREGS-1, that entry is written 0 and the FSM returns to IDLE; busy=0 at the same edge. A sweep takes exactly NREGS cycles.
REQ-021 CLEAR: clear_req is ignored, wr_en is ignored (no array update), and every rd_data is driven 0.
REQ-022 IDLE read: rd_en[i]=1 -> rd_data[i] takes the value of entry rd_addr[i] at the next edge (1-cycle latency); rd_en[i]=0 -> rd_data[i] holds its value.
REQ-023 IDLE write: wr_en[j]=1 -> entry wr_addr[j] takes wr_data[j] at the next edge.
REQ-024 Two or more enabled write ports with the same address in one cycle: the highest port index wins.
REQ-025 BYPASS=1: a read that matches an enabled same-cycle write address returns that write's data, with the winner chosen per REQ-024. BYPASS=0: the read returns the old entry value.
REQ-026 ZERO_REG=1: writes to address 0 are dropped; reads of address 0 return 0, including under bypass.
REQ-027 A clear_req arriving in the same cycle as writes: the writes complete in that cycle, then the sweep starts.

Reset
REQ-028 rstn=0 at an edge: state=CLEAR, idx=0, busy=1, all rd_data=0; array contents are not updated that cycle.
REQ-029 After rstn rises, a full NREGS-cycle sweep runs, then busy=0; the array is all-zero at that point.
REQ-030 rstn=0 during a sweep restarts the sweep at idx=0.

Structure
REQ-031 Package regfile_pkg holds the state enum (IDLE, CLEAR) and the default values of XLEN, NREGS, NRD and NWR.
REQ-032 The per-read-port write-priority and forwarding mux is a sub-module named regfile_fwd, instantiated NRD times.
REQ-033 Storage is a flat register array with no reset term; the zeroing of the array is done by the sweep only.

Verification
REQ-034 Reset for 1 cycle, release -> busy=1 for exactly 32 cycles, then 0; reads of all 32 entries return 0.
REQ-035 Write port 0: addr 5, data 0xDEADBEEF; next cycle read port 2 addr 5 -> rd_data[2]=0xDEADBEEF one cycle later.
REQ-036 Same cycle: port0 writes addr 7 = 0x11, port1 writes addr 7 = 0x22, read port0 addr 7 -> rd_data[0]=0x22 (bypass); a later read returns 0x22.
REQ-037 Write addr 0 = 0xFFFFFFFF with a same-cycle read of addr 0 -> rd_data=0, and later reads of addr 0 remain 0.
REQ-038 Fill entries 1..31, pulse clear_req, write addr 3 = 0x55 during busy -> after 32 cycles all entries read 0.
REQ-039 Assert rstn=0 at sweep cycle 10 -> the sweep restarts; busy stays high for 32 cycles after rstn rises.
